// File: rtl/boot_sequencer.sv
// boot_sequencer: program-load and run controller for the 16-bit CPU datapath.
// It holds the CPU in reset and can zero-fill the RAM first. It then writes the
// incoming program words through RAM port A, releases the CPU reset after a
// fixed hold, and supervises the run with a cycle counter, halt detection and
// a watchdog.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle pulse; starts a session from IDLE/DONE/TIMEOUT/ERROR
//   ld_valid     load stream word valid
//   ld_data      load stream word
//   ld_last      marks the final word of the program
//   ld_ready     block accepts a word (only in LOAD)
//   cpu_halt     CPU halt indication, level
//   mem_we       RAM port A write enable
//   mem_addr     RAM port A address
//   mem_data     RAM port A write data
//   cpu_reset_n  active-low reset to the CPU datapath
//   busy         high in CLEAR, LOAD, HOLD and RUN
//   done         high in DONE
//   timeout      high in TIMEOUT
//   error        high in ERROR (program overflow)
//   word_count   words loaded this session
//   cycle_count  RUN cycles this session
module boot_sequencer #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 1024,
  parameter int CLEAR_MEM    = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              cpu_halt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_HOLD, S_RUN, S_DONE, S_TIMEOUT, S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam int                HOLD_W      = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_data_reg, mem_data_next;
  logic [ADDR_W:0]     word_count_reg, word_count_next;
  logic [CNT_W-1:0]    cycle_count_reg, cycle_count_next;
  logic                cpu_reset_n_reg, busy_reg, done_reg, timeout_reg, error_reg;
  logic                transfer;

  assign ld_ready    = (state_reg == S_LOAD);
  assign transfer    = ld_ready && ld_valid;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_data    = mem_data_reg;
  assign word_count  = word_count_reg;
  assign cycle_count = cycle_count_reg;
  assign cpu_reset_n = cpu_reset_n_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign timeout     = timeout_reg;
  assign error       = error_reg;

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    mem_we_next      = 1'b0;
    mem_addr_next    = mem_addr_reg;
    mem_data_next    = mem_data_reg;
    word_count_next  = word_count_reg;
    cycle_count_next = cycle_count_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_TIMEOUT, S_ERROR: begin
        if (start) begin
          word_count_next  = '0;
          cycle_count_next = '0;
          if (CLEAR_MEM != 0) begin
            // The zero write to address 0 is issued on the entry edge, so
            // every CLEAR cycle carries exactly one write.
            state_next    = S_CLEAR;
            mem_we_next   = 1'b1;
            mem_addr_next = '0;
            mem_data_next = '0;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_CLEAR: begin
        if (mem_addr_reg == LAST_ADDR) begin
          state_next = S_LOAD;
        end else begin
          mem_we_next   = 1'b1;
          mem_addr_next = mem_addr_reg + 1'b1;
          mem_data_next = '0;
        end
      end
      S_LOAD: begin
        if (transfer) begin
          mem_we_next     = 1'b1;
          mem_addr_next   = word_count_reg[ADDR_W-1:0];
          mem_data_next   = ld_data;
          word_count_next = word_count_reg + 1'b1;
          if (ld_last) begin
            state_next    = S_HOLD;
            hold_cnt_next = '0;
          end else if (word_count_reg == {1'b0, LAST_ADDR}) begin
            // RAM is full and the program has not ended: overflow.
            state_next = S_ERROR;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) state_next = S_RUN;
        else                           hold_cnt_next = hold_cnt_reg + 1'b1;
      end
      S_RUN: begin
        // Halt takes priority over the watchdog in the same cycle.
        if (cpu_halt)
          state_next = S_DONE;
        else if (TIMEOUT != 0 && cycle_count_reg == TIMEOUT_CNT)
          state_next = S_TIMEOUT;
      end
      default: state_next = S_IDLE;
    endcase

    // Counting on entry into RUN makes the first RUN cycle read 1, and a
    // terminating cycle is already included in the count.
    if (state_next == S_RUN) cycle_count_next = cycle_count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      hold_cnt_reg    <= '0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_data_reg    <= '0;
      word_count_reg  <= '0;
      cycle_count_reg <= '0;
      cpu_reset_n_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      mem_we_reg      <= mem_we_next;
      mem_addr_reg    <= mem_addr_next;
      mem_data_reg    <= mem_data_next;
      word_count_reg  <= word_count_next;
      cycle_count_reg <= cycle_count_next;
      // Status flags are registered from the next state so they line up
      // with the state they describe.
      cpu_reset_n_reg <= (state_next == S_RUN);
      busy_reg        <= (state_next == S_CLEAR) || (state_next == S_LOAD) ||
                         (state_next == S_HOLD)  || (state_next == S_RUN);
      done_reg        <= (state_next == S_DONE);
      timeout_reg     <= (state_next == S_TIMEOUT);
      error_reg       <= (state_next == S_ERROR);
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Testbench for boot_sequencer. Instance a: ADDR_W=10, no clear, TIMEOUT=8.
// Instance b: ADDR_W=3, clear enabled, TIMEOUT=4. Expected RAM writes are
// queued when stimulus is driven and compared as each mem_we pulse appears.
module tb_boot_sequencer;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        cpu_halt;

  logic        a_start, a_ld_ready, a_mem_we, a_cpu_reset_n, a_busy, a_done, a_timeout, a_error;
  logic [9:0]  a_mem_addr;
  logic [15:0] a_mem_data;
  logic [10:0] a_word_count;
  logic [31:0] a_cycle_count;

  logic        b_start, b_ld_ready, b_mem_we, b_cpu_reset_n, b_busy, b_done, b_timeout, b_error;
  logic [2:0]  b_mem_addr;
  logic [15:0] b_mem_data;
  logic [3:0]  b_word_count;
  logic [31:0] b_cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [25:0] q_a[$];
  logic [25:0] q_b[$];
  logic [25:0] e_a, e_b;

  boot_sequencer #(.DATA_W(16), .ADDR_W(10), .RESET_CYCLES(2), .TIMEOUT(8),
                   .CLEAR_MEM(0), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(a_ld_ready),
    .cpu_halt(cpu_halt), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_data(a_mem_data), .cpu_reset_n(a_cpu_reset_n), .busy(a_busy),
    .done(a_done), .timeout(a_timeout), .error(a_error),
    .word_count(a_word_count), .cycle_count(a_cycle_count));

  boot_sequencer #(.DATA_W(16), .ADDR_W(3), .RESET_CYCLES(2), .TIMEOUT(4),
                   .CLEAR_MEM(1), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(b_ld_ready),
    .cpu_halt(cpu_halt), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_data(b_mem_data), .cpu_reset_n(b_cpu_reset_n), .busy(b_busy),
    .done(b_done), .timeout(b_timeout), .error(b_error),
    .word_count(b_word_count), .cycle_count(b_cycle_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Write monitors: one line per observed RAM write.
  always @(negedge clk) begin
    if (a_mem_we) begin
      $display("[%0t] a write addr=%0d data=0x%h", $time, a_mem_addr, a_mem_data);
      if (q_a.size() == 0) check("a_write_not_expected", 64'(a_mem_we), 64'd0);
      else begin
        e_a = q_a.pop_front();
        check("a_wr_addr", 64'(a_mem_addr), 64'(e_a[25:16]));
        check("a_wr_data", 64'(a_mem_data), 64'(e_a[15:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (b_mem_we) begin
      $display("[%0t] b write addr=%0d data=0x%h", $time, b_mem_addr, b_mem_data);
      if (q_b.size() == 0) check("b_write_not_expected", 64'(b_mem_we), 64'd0);
      else begin
        e_b = q_b.pop_front();
        check("b_wr_addr", 64'(b_mem_addr), 64'(e_b[25:16]));
        check("b_wr_data", 64'(b_mem_data), 64'(e_b[15:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; a_start = 1'b0; b_start = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; cpu_halt = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_a_mem_we", 64'(a_mem_we), 0);
    check("rst_a_ld_ready", 64'(a_ld_ready), 0);
    check("rst_a_cpu_reset_n", 64'(a_cpu_reset_n), 0);
    check("rst_a_flags", 64'({a_busy, a_done, a_timeout, a_error}), 0);
    check("rst_a_counts", 64'({a_word_count, a_cycle_count}), 0);
    check("rst_b_flags", 64'({b_busy, b_done, b_timeout, b_error, b_ld_ready}), 0);
    #2 reset = 1'b1;
    tick();

    // Load three words with a gap, then hold and run
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("a_ld_ready_in_load", 64'(a_ld_ready), 1);
    check("a_busy_in_load", 64'(a_busy), 1);
    q_a.push_back({10'd0, 16'h1111}); send(16'h1111, 1'b0);
    check("a_word_count_1", 64'(a_word_count), 1);
    repeat (2) tick();
    q_a.push_back({10'd1, 16'h2222}); send(16'h2222, 1'b0);
    q_a.push_back({10'd2, 16'h3333}); send(16'h3333, 1'b1);
    check("a_word_count_3", 64'(a_word_count), 3);
    check("a_ld_ready_in_hold", 64'(a_ld_ready), 0);
    n = 0;
    while (a_cpu_reset_n == 1'b0 && n < 10) begin n++; tick(); end
    check("a_hold_cycles", 64'(n), 2);
    check("a_run_cycle1_count", 64'(a_cycle_count), 1);
    check("a_busy_in_run", 64'(a_busy), 1);

    // Halt on the 5th RUN cycle
    repeat (4) tick();
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    check("a_done", 64'(a_done), 1);
    check("a_done_cycle_count", 64'(a_cycle_count), 5);
    check("a_done_cpu_reset_n", 64'(a_cpu_reset_n), 0);
    check("a_done_busy", 64'(a_busy), 0);
    check("a_done_timeout_error", 64'({a_timeout, a_error}), 0);

    // ld_valid outside LOAD must not write
    ld_valid = 1'b1; ld_data = 16'hDEAD; repeat (2) tick(); ld_valid = 1'b0;
    check("a_ld_ready_in_done", 64'(a_ld_ready), 0);

    // New session ending in watchdog timeout
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("a_restart_counts", 64'({a_word_count, a_cycle_count}), 0);
    check("a_restart_done_clr", 64'(a_done), 0);
    q_a.push_back({10'd0, 16'hABCD}); send(16'hABCD, 1'b1);
    n = 0;
    while (a_cpu_reset_n == 1'b0 && n < 10) begin n++; tick(); end
    check("a_hold_cycles_2", 64'(n), 2);
    n = 0;
    while (a_timeout == 1'b0 && n < 20) begin n++; tick(); end
    check("a_timeout_run_cycles", 64'(n), 8);
    check("a_timeout_cycle_count", 64'(a_cycle_count), 8);
    check("a_timeout_done", 64'(a_done), 0);
    check("a_timeout_cpu_reset_n", 64'(a_cpu_reset_n), 0);

    // Restart from TIMEOUT, then asynchronous reset after two words
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("a_reload_ready", 64'(a_ld_ready), 1);
    check("a_reload_counts", 64'({a_word_count, a_cycle_count}), 0);
    check("a_reload_timeout_clr", 64'(a_timeout), 0);
    q_a.push_back({10'd0, 16'hAAAA}); send(16'hAAAA, 1'b0);
    q_a.push_back({10'd1, 16'hBBBB}); send(16'hBBBB, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_mem_we", 64'(a_mem_we), 0);
    check("arst_mem_addr", 64'(a_mem_addr), 0);
    check("arst_mem_data", 64'(a_mem_data), 0);
    check("arst_ld_ready", 64'(a_ld_ready), 0);
    check("arst_busy", 64'(a_busy), 0);
    check("arst_word_count", 64'(a_word_count), 0);
    #2;
    // The second write was in flight and must never have appeared.
    check("arst_write_aborted", 64'(q_a.size()), 1);
    q_a.delete();
    reset = 1'b1;
    tick();
    check("arst_idle_word_count", 64'(a_word_count), 0);
    check("arst_idle_ready", 64'(a_ld_ready), 0);

    // Instance b: zero-fill, then overflow
    for (int i = 0; i < 8; i++) q_b.push_back({7'd0, 3'(i), 16'h0000});
    b_start = 1'b1; tick(); b_start = 1'b0;
    n = 0;
    while (b_ld_ready == 1'b0 && n < 20) begin n++; tick(); end
    check("b_clear_cycles", 64'(n), 8);
    check("b_we_after_clear", 64'(b_mem_we), 0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) q_b.push_back({7'd0, 3'(i), 16'h1000 + 16'(i)});
      else       check("b_ready_9th_word", 64'(b_ld_ready), 0);
      send(16'h1000 + 16'(i), 1'b0);
    end
    check("b_error", 64'(b_error), 1);
    check("b_overflow_word_count", 64'(b_word_count), 8);
    check("b_error_busy", 64'(b_busy), 0);

    // Instance b: halt on the cycle the watchdog limit is reached
    for (int i = 0; i < 8; i++) q_b.push_back({7'd0, 3'(i), 16'h0000});
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("b_restart_error_clr", 64'(b_error), 0);
    n = 0;
    while (b_ld_ready == 1'b0 && n < 20) begin n++; tick(); end
    check("b_clear_cycles_2", 64'(n), 8);
    q_b.push_back({7'd0, 3'd0, 16'h5A5A}); send(16'h5A5A, 1'b1);
    n = 0;
    while (b_cpu_reset_n == 1'b0 && n < 10) begin n++; tick(); end
    check("b_hold_cycles", 64'(n), 2);
    repeat (3) tick();
    check("b_run_cycle4", 64'(b_cycle_count), 4);
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    check("b_halt_at_limit_done", 64'(b_done), 1);
    check("b_halt_at_limit_timeout", 64'(b_timeout), 0);
    check("b_halt_cycle_count", 64'(b_cycle_count), 4);

    repeat (2) tick();
    check("a_queue_empty", 64'(q_a.size()), 0);
    check("b_queue_empty", 64'(q_b.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
